// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths and the clear-engine state encoding.
package npu_pkg;

  localparam int NPU_DATA_W = 8;
  localparam int NPU_ADDR_W = 14;

  typedef enum logic {
    CLEAR_IDLE = 1'b0,
    CLEAR_FILL = 1'b1
  } clear_state_t;

endpackage

// File: rtl/conv_ram_sdp.sv
// Bare simple-dual-port RAM with one registered read port; a same-address
// read and write in one cycle returns the old contents.
module conv_ram_sdp
  import npu_pkg::*;
#(
  parameter int DATA_W = NPU_DATA_W,
  parameter int ADDR_W = NPU_ADDR_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  (* ramstyle = "M10K" *) logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_buffer.sv
// Convolution buffer: SDP RAM with a clear/fill engine, optional write-to-read
// forwarding and a one- or two-cycle read pipeline with a valid strobe.
module conv_buffer
  import npu_pkg::*;
#(
  parameter int                DATA_W    = NPU_DATA_W,
  parameter int                ADDR_W    = NPU_ADDR_W,
  parameter int                READ_LAT  = 1,
  parameter bit                BYPASS    = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q,
  output logic              rd_valid,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  clear_state_t      state, state_next;
  logic [ADDR_W:0]   cnt, cnt_next;
  logic              done_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] ram_q;

  logic              valid1;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [DATA_W-1:0] stage1_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR_IDLE;
      cnt        <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      clear_done <= done_next;
    end
  end

  // The counter is one bit wider than the address so the last address is
  // recognised directly rather than through a wrap to zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      CLEAR_IDLE: begin
        if (clear_start) begin
          state_next = CLEAR_FILL;
          cnt_next   = '0;
        end
      end
      CLEAR_FILL: begin
        cnt_next = cnt + CNT_ONE;
        if (cnt == LAST_CNT) begin
          state_next = CLEAR_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = CLEAR_IDLE;
    endcase
  end

  assign clear_busy = (state == CLEAR_FILL);
  assign wr_ready   = ~clear_busy;

  // Writes are suppressed in a reset cycle so a reset mid-fill stops at once.
  assign mem_we    = ~reset & (clear_busy | wr_en);
  assign mem_waddr = clear_busy ? cnt[ADDR_W-1:0] : wr_addr;
  assign mem_wdata = clear_busy ? CLEAR_VAL : wr_data;

  conv_ram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid1  <= 1'b0;
      byp_hit <= 1'b0;
    end else begin
      valid1  <= rd_en;
      byp_hit <= BYPASS && rd_en && mem_we && (rd_addr == mem_waddr);
    end
  end

  always_ff @(posedge clock) begin
    byp_data <= mem_wdata;
  end

  assign stage1_data = byp_hit ? byp_data : ram_q;

  // The RAM output itself cannot be reset, so q is masked by a held copy
  // whenever no new read result is being presented.
  generate
    if (READ_LAT == 1) begin : g_lat1
      logic [DATA_W-1:0] q_hold;

      always_ff @(posedge clock) begin
        if (reset)       q_hold <= '0;
        else if (valid1) q_hold <= stage1_data;
      end

      assign q        = valid1 ? stage1_data : q_hold;
      assign rd_valid = valid1;
    end else begin : g_lat2
      logic [DATA_W-1:0] q_reg;
      logic              valid2;

      always_ff @(posedge clock) begin
        if (reset) begin
          q_reg  <= '0;
          valid2 <= 1'b0;
        end else begin
          valid2 <= valid1;
          if (valid1) q_reg <= stage1_data;
        end
      end

      assign q        = q_reg;
      assign rd_valid = valid2;
    end
  endgenerate

endmodule
